branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

EX-side counterpart of the IF-stage branch target buffer. It carries each fetched instruction's prediction (hit bit, predicted target, PC) through the IF/ID and ID/EX pipeline registers. When the instruction resolves in EX, the block compares the prediction with the actual outcome. It then produces the BTB write-back (update, taken flag, entry index, target) and the front-end redirect/flush on a misprediction, and keeps saturating branch and mispredict counters.

## Interface
Parameters:
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pc_if  in  32  PC of instruction in IF
- pred_taken_if  in  1  BTB hit/predict-taken from IF
- pred_pc_if  in  32  BTB predicted target from IF
- stall_id  in  1  hold IF/ID prediction register
- stall_ex  in  1  hold ID/EX prediction register; suppresses resolution
- bubble_ex  in  1  external hazard bubble into EX
- ex_is_branch  in  1  EX instruction is branch/jal/jalr
- ex_taken  in  1  actual outcome in EX
- ex_target  in  32  actual target in EX
- btb_update  out  1  write BTB at next edge
- btb_real  out  1  1 = install/refresh entry, 0 = invalidate
- btb_update_entry  out  30  word PC of resolving instruction (pc_ex[31:2])
- btb_update_pc  out  32  target to install
- redirect  out  1  mispredict: flush IF/ID/EX-younger, refetch
- redirect_pc  out  32  correct next PC
- branch_cnt  out  CNT_W  resolved branches
- mispredict_cnt  out  CNT_W  mispredictions

## Operation
- Stage records {valid, taken, pred_pc, pc} exist for ID and EX. IF record is formed from inputs, valid=1.
- IF/ID load priority: rst → invalid; redirect → invalid; stall_id → hold; else capture IF record.
- ID/EX load priority: rst → invalid; redirect → invalid; stall_ex → hold; bubble_ex → invalid; else capture ID record.
- Resolution fires when ex.valid && !stall_ex (exactly once per instruction). Otherwise all update/redirect outputs are 0.
- Cases on firing:
  - Branch, taken, not predicted: update, real=1, btb_update_pc=ex_target; redirect to ex_target.
  - Branch, taken, predicted, pred_pc≠ex_target: same as previous case.
  - Branch, taken, predicted, pred_pc==ex_target: no update, no redirect.
  - Branch, not taken, predicted: update, real=0; redirect to ex.pc+4.
  - Branch, not taken, not predicted: nothing.
  - Non-branch, predicted (alias): update, real=0; redirect ex.pc+4.
- btb_update_entry = ex.pc[31:2] on every update. btb_update_pc = ex_target when real=1, don't-care (drive 0) when real=0.
- PC+4 wraps modulo 2^32.
- branch_cnt +1 per fired branch. mispredict_cnt +1 per redirect. Both saturate at all-ones.

## Timing
- Reset: all records invalid; btb_update, btb_real, redirect = 0; btb_update_entry, btb_update_pc, redirect_pc = 0; counters = 0.
- Update/redirect outputs are combinational from the EX record and ex_* inputs, valid in the resolving cycle. The BTB writes at the following edge, and the front end loads redirect_pc at the following edge.
- Redirect in cycle N: ID and EX records are invalid at N+1, overriding stall_id/stall_ex. The instruction fetched at N+1 (redirect_pc) is the first valid one.
- Prediction latency IF→EX: 2 cycles with no stalls.
- The same instruction PC in IF at the edge BTB updates sees the new entry next cycle, not the same cycle.
- rst asserted mid-stream: records cleared at that edge, counters cleared, no update emitted during rst.

## Structure
- Shared package bp_pkg:
  - typedef bp_rec_t {valid, taken, pred_pc[31:0], pc[31:0]}
  - constant PC_STEP=4
  - constant BTB_ENTRY_W=30
- Sub-module bp_stage_reg: one bp_rec_t register with rst/flush/hold/bubble priority. Instantiated twice (ID, EX).

## Test plan
- Branch at 0x100, no BTB hit, taken to 0x200 → 2 cycles later btb_update=1, btb_real=1, entry=0x40, btb_update_pc=0x200, redirect_pc=0x200; branch_cnt=1, mispredict_cnt=1.
- Same branch predicted taken to 0x200, taken to 0x200 → no update, no redirect, branch_cnt increments only.
- Predicted taken to 0x200, resolves not taken → btb_real=0, entry=0x40, redirect_pc=0x104.
- Non-branch at 0x300 predicted taken → invalidate entry 0xC0, redirect_pc=0x304, branch_cnt unchanged.
- Mispredict with stall_ex=1 for 3 cycles → outputs 0 while stalled, single update/redirect on release; next instruction in ID invalidated despite stall_id=1.
- mispredict_cnt preloaded near max (CNT_W=4, 15) plus another mispredict → stays 15. rst mid-stream → all outputs 0 the next cycle.

Source files
------------

// File: rtl/bp_pkg.sv
// Branch prediction types shared by the IF-to-EX prediction pipeline and resolver.
package bp_pkg;

  localparam int PC_STEP     = 4;
  localparam int BTB_ENTRY_W = 30;

  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] pred_pc;
    logic [31:0] pc;
  } bp_rec_t;

endpackage

// File: rtl/bp_stage_reg.sv
// One pipeline register for a prediction record.
// Priority order: reset, flush, hold, bubble, then load.
module bp_stage_reg
  import bp_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    flush_i,
  input  logic    hold_i,
  input  logic    bubble_i,
  input  bp_rec_t rec_i,
  output bp_rec_t rec_o
);

  bp_rec_t rec_q, rec_d;

  always_comb begin
    rec_d = rec_i;
    if (flush_i)       rec_d = '0;
    else if (hold_i)   rec_d = rec_q;
    else if (bubble_i) rec_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) rec_q <= '0;
    else     rec_q <= rec_d;
  end

  assign rec_o = rec_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries IF-stage BTB predictions to EX and resolves them.
// Outputs: BTB write-back, mispredict redirect, and saturating statistics.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            pc_if,
  input  logic                   pred_taken_if,
  input  logic [31:0]            pred_pc_if,
  input  logic                   stall_id,
  input  logic                   stall_ex,
  input  logic                   bubble_ex,
  input  logic                   ex_is_branch,
  input  logic                   ex_taken,
  input  logic [31:0]            ex_target,
  output logic                   btb_update,
  output logic                   btb_real,
  output logic [BTB_ENTRY_W-1:0] btb_update_entry,
  output logic [31:0]            btb_update_pc,
  output logic                   redirect,
  output logic [31:0]            redirect_pc,
  output logic [CNT_W-1:0]       branch_cnt,
  output logic [CNT_W-1:0]       mispredict_cnt
);

  bp_rec_t if_rec, id_rec, ex_rec;

  assign if_rec = '{valid: 1'b1, taken: pred_taken_if, pred_pc: pred_pc_if, pc: pc_if};

  bp_stage_reg u_id_reg (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (redirect),
    .hold_i   (stall_id),
    .bubble_i (1'b0),
    .rec_i    (if_rec),
    .rec_o    (id_rec)
  );

  bp_stage_reg u_ex_reg (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (redirect),
    .hold_i   (stall_ex),
    .bubble_i (bubble_ex),
    .rec_i    (id_rec),
    .rec_o    (ex_rec)
  );

  // Gating on rst keeps a stale EX record from writing the BTB while reset is held.
  logic fire, fix_taken, kill_entry;

  assign fire       = ex_rec.valid && !stall_ex && !rst;
  assign fix_taken  = ex_is_branch && ex_taken &&
                      (!ex_rec.taken || (ex_rec.pred_pc != ex_target));
  assign kill_entry = ex_rec.taken && (!ex_is_branch || !ex_taken);

  always_comb begin
    btb_update       = 1'b0;
    btb_real         = 1'b0;
    btb_update_entry = '0;
    btb_update_pc    = '0;
    redirect         = 1'b0;
    redirect_pc      = '0;
    if (fire) begin
      if (fix_taken) begin
        btb_update    = 1'b1;
        btb_real      = 1'b1;
        btb_update_pc = ex_target;
        redirect      = 1'b1;
        redirect_pc   = ex_target;
      end else if (kill_entry) begin
        btb_update  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = ex_rec.pc + 32'(PC_STEP);
      end
    end
    if (btb_update) btb_update_entry = ex_rec.pc[31:2];
  end

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (fire && ex_is_branch && (branch_cnt_q != '1))
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    if (redirect && (mispredict_cnt_q != '1))
      mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit with narrow counters to reach saturation.
module tb_branch_resolve_unit;

  localparam int CW = 4;
  localparam logic [31:0] IDLE_PC = 32'h0000_1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [31:0]   pc_if, pred_pc_if, ex_target;
  logic          pred_taken_if, stall_id, stall_ex, bubble_ex, ex_is_branch, ex_taken;
  logic          btb_update, btb_real, redirect;
  logic [29:0]   btb_update_entry;
  logic [31:0]   btb_update_pc, redirect_pc;
  logic [CW-1:0] branch_cnt, mispredict_cnt;

  branch_resolve_unit #(.CNT_W(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_if            (pc_if),
    .pred_taken_if    (pred_taken_if),
    .pred_pc_if       (pred_pc_if),
    .stall_id         (stall_id),
    .stall_ex         (stall_ex),
    .bubble_ex        (bubble_ex),
    .ex_is_branch     (ex_is_branch),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .btb_update       (btb_update),
    .btb_real         (btb_real),
    .btb_update_entry (btb_update_entry),
    .btb_update_pc    (btb_update_pc),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .branch_cnt       (branch_cnt),
    .mispredict_cnt   (mispredict_cnt)
  );

  typedef struct {
    logic          upd;
    logic          rl;
    logic [29:0]   entry;
    logic [31:0]   upc;
    logic          redir;
    logic [31:0]   rpc;
    logic [CW-1:0] bcnt;
    logic [CW-1:0] mcnt;
  } exp_t;

  exp_t          sb[$];
  logic [CW-1:0] m_bcnt, m_mcnt;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == '1) ? c : c + CW'(1);
  endfunction

  // Expected resolution of one EX record, straight from the outcome table.
  task automatic push_exp(input logic v, input logic pred, input logic [31:0] ppc,
                          input logic [31:0] pc, input logic isbr, input logic tk,
                          input logic [31:0] tgt, output logic redir);
    exp_t e;
    e = '{upd: 1'b0, rl: 1'b0, entry: '0, upc: '0, redir: 1'b0, rpc: '0, bcnt: '0, mcnt: '0};
    if (v) begin
      if (isbr && tk && (!pred || ppc != tgt)) begin
        e.upd = 1'b1; e.rl = 1'b1; e.upc = tgt; e.redir = 1'b1; e.rpc = tgt;
      end else if (pred && (!isbr || !tk)) begin
        e.upd = 1'b1; e.rl = 1'b0; e.redir = 1'b1; e.rpc = pc + 32'd4;
      end
      e.entry = pc[31:2];
      if (isbr) m_bcnt = sat_inc(m_bcnt);
      if (e.redir) m_mcnt = sat_inc(m_mcnt);
    end
    e.bcnt = m_bcnt;
    e.mcnt = m_mcnt;
    sb.push_back(e);
    redir = e.redir;
  endtask

  task automatic compare_out(input string tag, output exp_t e);
    e = '{upd: 1'b0, rl: 1'b0, entry: '0, upc: '0, redir: 1'b0, rpc: '0, bcnt: m_bcnt, mcnt: m_mcnt};
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: scoreboard empty got nothing expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "/upd"},   32'(btb_update), 32'(e.upd));
    chk({tag, "/redir"}, 32'(redirect),   32'(e.redir));
    if (e.upd) begin
      chk({tag, "/real"},  32'(btb_real),         32'(e.rl));
      chk({tag, "/entry"}, 32'(btb_update_entry), 32'(e.entry));
      if (e.rl) chk({tag, "/upc"}, btb_update_pc, e.upc);
    end
    if (e.redir) chk({tag, "/rpc"}, redirect_pc, e.rpc);
  endtask

  task automatic check_cnt(input string tag, input exp_t e);
    chk({tag, "/bcnt"}, 32'(branch_cnt),     32'(e.bcnt));
    chk({tag, "/mcnt"}, 32'(mispredict_cnt), 32'(e.mcnt));
  endtask

  // One instruction through IF/ID/EX, followed by a filler (pc 0x500) one slot behind it.
  task automatic run(input string tag, input logic [31:0] pc, input logic pred,
                     input logic [31:0] ppc, input logic isbr, input logic tk,
                     input logic [31:0] tgt, input logic fp, input logic bub, input int stall);
    logic r0, r1;
    exp_t e;
    @(negedge clk);
    pc_if = pc; pred_taken_if = pred; pred_pc_if = ppc;
    ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = '0;
    push_exp(!bub, pred, ppc, pc, isbr, tk, tgt, r0);
    push_exp(!r0, fp, 32'h600, 32'h500, 1'b0, 1'b0, 32'h0, r1);
    @(negedge clk);
    pc_if = 32'h500; pred_taken_if = fp; pred_pc_if = 32'h600; bubble_ex = bub;
    @(negedge clk);
    pc_if = IDLE_PC; pred_taken_if = 1'b0; pred_pc_if = '0; bubble_ex = 1'b0;
    ex_is_branch = isbr; ex_taken = tk; ex_target = tgt;
    if (stall > 0) begin
      stall_ex = 1'b1; stall_id = 1'b1;
      for (int i = 0; i < stall; i++) begin
        #1;
        chk({tag, "/stall_upd"},   32'(btb_update), 32'h0);
        chk({tag, "/stall_redir"}, 32'(redirect),   32'h0);
        @(negedge clk);
      end
      stall_ex = 1'b0;
    end
    compare_out({tag, "/ex"}, e);
    @(negedge clk);
    stall_id = 1'b0; ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = '0;
    check_cnt({tag, "/ex"}, e);
    compare_out({tag, "/filler"}, e);
    @(negedge clk);
    check_cnt({tag, "/filler"}, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pc_if = IDLE_PC; pred_taken_if = 1'b0; pred_pc_if = '0;
    stall_id = 1'b0; stall_ex = 1'b0; bubble_ex = 1'b0;
    ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = '0;
    m_bcnt = '0; m_mcnt = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst/upd",   32'(btb_update),       32'h0);
    chk("rst/real",  32'(btb_real),         32'h0);
    chk("rst/redir", 32'(redirect),         32'h0);
    chk("rst/entry", 32'(btb_update_entry), 32'h0);
    chk("rst/upc",   btb_update_pc,         32'h0);
    chk("rst/rpc",   redirect_pc,           32'h0);
    chk("rst/bcnt",  32'(branch_cnt),       32'h0);
    chk("rst/mcnt",  32'(mispredict_cnt),   32'h0);
    rst = 1'b0;

    //   tag            pc            pred  ppc      br    tk    tgt      fp    bub   stall
    run("miss_taken",   32'h100,      1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 0);
    run("hit_ok",       32'h100,      1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 0);
    run("hit_wrong",    32'h100,      1'b1, 32'h180, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 0);
    run("pred_nt",      32'h100,      1'b1, 32'h200, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 0);
    run("alias",        32'h300,      1'b1, 32'h400, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 0);
    run("nt_np",        32'h140,      1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 0);
    run("wrap",         32'hFFFFFFFC, 1'b1, 32'h8,   1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 0);
    run("bubble",       32'h100,      1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 0);
    run("stall",        32'h100,      1'b0, 32'h0,   1'b1, 1'b1, 32'h240, 1'b1, 1'b0, 3);
    for (int i = 0; i < 16; i++)
      run("sat", 32'h100 + 32'(i * 4), 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 0);

    // Reset asserted while a mispredicting branch sits in EX.
    @(negedge clk);
    pc_if = 32'h100; pred_taken_if = 1'b0; pred_pc_if = '0;
    @(negedge clk);
    pc_if = IDLE_PC;
    @(negedge clk);
    ex_is_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h200; rst = 1'b1;
    #1;
    chk("midrst/upd",   32'(btb_update), 32'h0);
    chk("midrst/real",  32'(btb_real),   32'h0);
    chk("midrst/redir", 32'(redirect),   32'h0);
    @(negedge clk);
    rst = 1'b0; ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = '0;
    m_bcnt = '0; m_mcnt = '0;
    #1;
    chk("postrst/upd",   32'(btb_update),     32'h0);
    chk("postrst/redir", 32'(redirect),       32'h0);
    chk("postrst/bcnt",  32'(branch_cnt),     32'(m_bcnt));
    chk("postrst/mcnt",  32'(mispredict_cnt), 32'(m_mcnt));
    chk("sb_empty",      32'(sb.size()),      32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
